// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard
//
// Integer register file for the RISCV32 core, combined with a pending-write
// scoreboard. Decode reads two operands and may issue an instruction only
// when neither source nor the destination has a write outstanding. Writeback
// retires results into the file and clears the matching busy bit. All
// registers are exported every cycle as a debug view.
//
// Ports:
//   clock              rising-edge clock for all state
//   reset              synchronous, active-low reset (0 = reset)
//   io_rs1_addr/data   operand 1 index / value (combinational, wb bypass)
//   io_rs2_addr/data   operand 2 index / value (combinational, wb bypass)
//   io_issue_valid/rd  issue request and its destination (0 = none)
//   io_issue_ready     no RAW/WAW hazard for the presented indices
//   io_wb_valid/rd/data  writeback of a result
//   io_busy            registered scoreboard mask, bit i = write pending on xi
//   io_pending         registered count of outstanding writes
//   io_err             sticky flag: writeback arrived with no matching issue
//   io_regs_0..31      registered register contents, no bypass
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       io_rs1_addr,
    input  logic [4:0]       io_rs2_addr,
    output logic [XLEN-1:0]  io_rs1_data,
    output logic [XLEN-1:0]  io_rs2_data,
    input  logic             io_issue_valid,
    input  logic [4:0]       io_issue_rd,
    output logic             io_issue_ready,
    input  logic             io_wb_valid,
    input  logic [4:0]       io_wb_rd,
    input  logic [XLEN-1:0]  io_wb_data,
    output logic [NREGS-1:0] io_busy,
    output logic [5:0]       io_pending,
    output logic             io_err,
    output logic [XLEN-1:0]  io_regs_0,
    output logic [XLEN-1:0]  io_regs_1,
    output logic [XLEN-1:0]  io_regs_2,
    output logic [XLEN-1:0]  io_regs_3,
    output logic [XLEN-1:0]  io_regs_4,
    output logic [XLEN-1:0]  io_regs_5,
    output logic [XLEN-1:0]  io_regs_6,
    output logic [XLEN-1:0]  io_regs_7,
    output logic [XLEN-1:0]  io_regs_8,
    output logic [XLEN-1:0]  io_regs_9,
    output logic [XLEN-1:0]  io_regs_10,
    output logic [XLEN-1:0]  io_regs_11,
    output logic [XLEN-1:0]  io_regs_12,
    output logic [XLEN-1:0]  io_regs_13,
    output logic [XLEN-1:0]  io_regs_14,
    output logic [XLEN-1:0]  io_regs_15,
    output logic [XLEN-1:0]  io_regs_16,
    output logic [XLEN-1:0]  io_regs_17,
    output logic [XLEN-1:0]  io_regs_18,
    output logic [XLEN-1:0]  io_regs_19,
    output logic [XLEN-1:0]  io_regs_20,
    output logic [XLEN-1:0]  io_regs_21,
    output logic [XLEN-1:0]  io_regs_22,
    output logic [XLEN-1:0]  io_regs_23,
    output logic [XLEN-1:0]  io_regs_24,
    output logic [XLEN-1:0]  io_regs_25,
    output logic [XLEN-1:0]  io_regs_26,
    output logic [XLEN-1:0]  io_regs_27,
    output logic [XLEN-1:0]  io_regs_28,
    output logic [XLEN-1:0]  io_regs_29,
    output logic [XLEN-1:0]  io_regs_30,
    output logic [XLEN-1:0]  io_regs_31
);

    // Entry 0 is reset to zero and never written, so x0 reads as 0 everywhere.
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [5:0]       pending_q, pending_d;
    logic             err_q, err_d;

    logic             wbHit;
    logic             wbWasBusy;
    logic             issueFire;
    logic [NREGS-1:0] wbMask;
    logic [NREGS-1:0] issueMask;
    logic [NREGS-1:0] effBusy;

    // A writeback in flight this cycle hides the busy bit it is about to
    // clear, so a dependent instruction can issue with the bypassed operand.
    always_comb begin
        wbHit  = io_wb_valid && (io_wb_rd != 5'd0);
        wbMask = '0;
        if (wbHit) begin
            wbMask[io_wb_rd] = 1'b1;
        end
        effBusy = busy_q & ~wbMask;
    end

    assign io_issue_ready = !effBusy[io_rs1_addr]
                         && !effBusy[io_rs2_addr]
                         && !effBusy[io_issue_rd];

    // Scoreboard next state. The issue set is OR-ed in after the writeback
    // clear so that a same-cycle issue to the retiring index leaves it busy.
    always_comb begin
        issueFire = io_issue_valid && io_issue_ready && (io_issue_rd != 5'd0);
        issueMask = '0;
        if (issueFire) begin
            issueMask[io_issue_rd] = 1'b1;
        end
        wbWasBusy = wbHit && busy_q[io_wb_rd];
        busy_d    = (busy_q & ~wbMask) | issueMask;
        busy_d[0] = 1'b0;
        pending_d = pending_q + {5'd0, issueFire} - {5'd0, wbWasBusy};
        err_d     = err_q | (wbHit && !busy_q[io_wb_rd]);
    end

    // Write-first read ports: x0 is hardwired, then the writeback value,
    // then the stored register.
    always_comb begin
        io_rs1_data = regs_q[io_rs1_addr];
        if (io_rs1_addr == 5'd0) begin
            io_rs1_data = '0;
        end else if (wbHit && (io_wb_rd == io_rs1_addr)) begin
            io_rs1_data = io_wb_data;
        end
    end

    always_comb begin
        io_rs2_data = regs_q[io_rs2_addr];
        if (io_rs2_addr == 5'd0) begin
            io_rs2_data = '0;
        end else if (wbHit && (io_wb_rd == io_rs2_addr)) begin
            io_rs2_data = io_wb_data;
        end
    end

    // Reset overrides any same-cycle issue or writeback.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (wbHit) begin
                regs_q[io_wb_rd] <= io_wb_data;
            end
            busy_q    <= busy_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign io_busy    = busy_q;
    assign io_pending = pending_q;
    assign io_err     = err_q;

    assign io_regs_0  = regs_q[0];
    assign io_regs_1  = regs_q[1];
    assign io_regs_2  = regs_q[2];
    assign io_regs_3  = regs_q[3];
    assign io_regs_4  = regs_q[4];
    assign io_regs_5  = regs_q[5];
    assign io_regs_6  = regs_q[6];
    assign io_regs_7  = regs_q[7];
    assign io_regs_8  = regs_q[8];
    assign io_regs_9  = regs_q[9];
    assign io_regs_10 = regs_q[10];
    assign io_regs_11 = regs_q[11];
    assign io_regs_12 = regs_q[12];
    assign io_regs_13 = regs_q[13];
    assign io_regs_14 = regs_q[14];
    assign io_regs_15 = regs_q[15];
    assign io_regs_16 = regs_q[16];
    assign io_regs_17 = regs_q[17];
    assign io_regs_18 = regs_q[18];
    assign io_regs_19 = regs_q[19];
    assign io_regs_20 = regs_q[20];
    assign io_regs_21 = regs_q[21];
    assign io_regs_22 = regs_q[22];
    assign io_regs_23 = regs_q[23];
    assign io_regs_24 = regs_q[24];
    assign io_regs_25 = regs_q[25];
    assign io_regs_26 = regs_q[26];
    assign io_regs_27 = regs_q[27];
    assign io_regs_28 = regs_q[28];
    assign io_regs_29 = regs_q[29];
    assign io_regs_30 = regs_q[30];
    assign io_regs_31 = regs_q[31];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard
//
// Directed bench for regfile_scoreboard. A behavioural model of the register
// file and scoreboard (plain arrays, updated from the operation rules) is
// compared against every DUT output on each falling edge; literal checks at
// key points pin the model to hand-computed values.
// ============================================================================
module tb_regfile_scoreboard;

    logic              clock;
    logic              reset;
    logic [4:0]        rs1Addr, rs2Addr;
    logic [31:0]       rs1Data, rs2Data;
    logic              issueValid;
    logic [4:0]        issueRd;
    logic              issueReady;
    logic              wbValid;
    logic [4:0]        wbRd;
    logic [31:0]       wbData;
    logic [31:0]       busy;
    logic [5:0]        pending;
    logic              err;
    logic [31:0][31:0] dutRegs;

    int testsRun  = 0;
    int failCount = 0;
    bit checkEn   = 0;

    // Behavioural model state
    logic [31:0] mRegs [32];
    bit          mBusy [32];
    bit          mErr;

    regfile_scoreboard #(.XLEN(32), .NREGS(32)) dut (
        .clock(clock), .reset(reset),
        .io_rs1_addr(rs1Addr), .io_rs2_addr(rs2Addr),
        .io_rs1_data(rs1Data), .io_rs2_data(rs2Data),
        .io_issue_valid(issueValid), .io_issue_rd(issueRd),
        .io_issue_ready(issueReady),
        .io_wb_valid(wbValid), .io_wb_rd(wbRd), .io_wb_data(wbData),
        .io_busy(busy), .io_pending(pending), .io_err(err),
        .io_regs_0(dutRegs[0]),   .io_regs_1(dutRegs[1]),
        .io_regs_2(dutRegs[2]),   .io_regs_3(dutRegs[3]),
        .io_regs_4(dutRegs[4]),   .io_regs_5(dutRegs[5]),
        .io_regs_6(dutRegs[6]),   .io_regs_7(dutRegs[7]),
        .io_regs_8(dutRegs[8]),   .io_regs_9(dutRegs[9]),
        .io_regs_10(dutRegs[10]), .io_regs_11(dutRegs[11]),
        .io_regs_12(dutRegs[12]), .io_regs_13(dutRegs[13]),
        .io_regs_14(dutRegs[14]), .io_regs_15(dutRegs[15]),
        .io_regs_16(dutRegs[16]), .io_regs_17(dutRegs[17]),
        .io_regs_18(dutRegs[18]), .io_regs_19(dutRegs[19]),
        .io_regs_20(dutRegs[20]), .io_regs_21(dutRegs[21]),
        .io_regs_22(dutRegs[22]), .io_regs_23(dutRegs[23]),
        .io_regs_24(dutRegs[24]), .io_regs_25(dutRegs[25]),
        .io_regs_26(dutRegs[26]), .io_regs_27(dutRegs[27]),
        .io_regs_28(dutRegs[28]), .io_regs_29(dutRegs[29]),
        .io_regs_30(dutRegs[30]), .io_regs_31(dutRegs[31])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic iv, input logic [4:0] ird,
                                 input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
        @(posedge clock);
        #1;
        reset      = rstN;
        rs1Addr    = r1;
        rs2Addr    = r2;
        issueValid = iv;
        issueRd    = ird;
        wbValid    = wv;
        wbRd       = wrd;
        wbData     = wd;
    endtask

    // Model view of the combinational outputs
    function automatic logic [31:0] modelRead(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wbValid && wbRd == a) return wbData;
        return mRegs[a];
    endfunction

    function automatic bit modelHazard(input logic [4:0] a);
        return mBusy[a] && !(wbValid && wbRd == a);
    endfunction

    function automatic bit modelReady();
        return !modelHazard(rs1Addr) && !modelHazard(rs2Addr) && !modelHazard(issueRd);
    endfunction

    // Model update at each rising edge from the inputs presented this cycle
    always @(posedge clock) begin
        bit iss;
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mRegs[i] = 32'd0;
                mBusy[i] = 1'b0;
            end
            mErr = 1'b0;
        end else begin
            iss = issueValid && modelReady() && issueRd != 0;
            if (wbValid && wbRd != 0) begin
                mRegs[wbRd] = wbData;
                if (!mBusy[wbRd]) mErr = 1'b1;
                mBusy[wbRd] = 1'b0;
            end
            if (iss) mBusy[issueRd] = 1'b1;
        end
    end

    // Compare process: every DUT output against the model on each falling edge
    always @(negedge clock) begin
        if (checkEn) begin
            logic [31:0] expBusy;
            int          cnt;
            expBusy = 32'd0;
            cnt     = 0;
            for (int i = 0; i < 32; i++) begin
                expBusy[i] = mBusy[i];
                if (mBusy[i]) cnt++;
            end
            checkOutput("rs1_data", rs1Data, modelRead(rs1Addr));
            checkOutput("rs2_data", rs2Data, modelRead(rs2Addr));
            checkOutput("issue_ready", {31'd0, issueReady}, {31'd0, modelReady()});
            checkOutput("busy", busy, expBusy);
            checkOutput("pending", {26'd0, pending}, cnt);
            checkOutput("err", {31'd0, err}, {31'd0, mErr});
            for (int i = 0; i < 32; i++) begin
                checkOutput($sformatf("regs_%0d", i), dutRegs[i], mRegs[i]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mRegs[i] = 32'd0;
            mBusy[i] = 1'b0;
        end
        mErr       = 1'b0;
        reset      = 1'b0;
        rs1Addr    = 5'd0;
        rs2Addr    = 5'd0;
        issueValid = 1'b0;
        issueRd    = 5'd0;
        wbValid    = 1'b0;
        wbRd       = 5'd0;
        wbData     = 32'd0;

        // Reset state
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkEn = 1;
        checkOutput("lit_reset_ready", {31'd0, issueReady}, 32'd1);
        checkOutput("lit_reset_busy", busy, 32'd0);
        checkOutput("lit_reset_pending", {26'd0, pending}, 32'd0);
        checkOutput("lit_reset_err", {31'd0, err}, 32'd0);

        // Issue x5, then write it back with a bypassed read
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clock);
        checkOutput("lit_x5_bypass", rs1Data, 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_x5_regs", dutRegs[5], 32'hDEADBEEF);
        checkOutput("lit_x5_busy", busy, 32'd0);
        checkOutput("lit_x5_pending", {26'd0, pending}, 32'd0);
        checkOutput("lit_x5_err", {31'd0, err}, 32'd0);

        // Writeback to x0 is ignored
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h12345678);
        @(negedge clock);
        checkOutput("lit_x0_read", rs1Data, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_x0_regs", dutRegs[0], 32'd0);
        checkOutput("lit_x0_err", {31'd0, err}, 32'd0);
        checkOutput("lit_x0_pending", {26'd0, pending}, 32'd0);

        // RAW hazard on x7 until its writeback cycle
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_x7_stall1", {31'd0, issueReady}, 32'd0);
        applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_x7_stall2", {31'd0, issueReady}, 32'd0);
        applyStimulus(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5);
        @(negedge clock);
        checkOutput("lit_x7_ready", {31'd0, issueReady}, 32'd1);
        checkOutput("lit_x7_rs1", rs1Data, 32'hA5A5A5A5);
        checkOutput("lit_x7_rs2", rs2Data, 32'hA5A5A5A5);

        // Issue x3 while x3 retires: it stays busy
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3, 32'h33333333);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_x3_busy", busy, 32'h00000008);
        checkOutput("lit_x3_pending", {26'd0, pending}, 32'd1);
        checkOutput("lit_x3_regs", dutRegs[3], 32'h33333333);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h44444444);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_x3_drained", {26'd0, pending}, 32'd0);

        // Unmatched writeback to x9 sets the sticky error
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99999999);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_x9_err", {31'd0, err}, 32'd1);
        checkOutput("lit_x9_regs", dutRegs[9], 32'h99999999);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_x9_sticky", {31'd0, err}, 32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_err_cleared", {31'd0, err}, 32'd0);
        checkOutput("lit_x9_cleared", dutRegs[9], 32'd0);

        // Fill the scoreboard with x1..x31
        for (int k = 1; k < 32; k++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, k[4:0], 1'b0, 5'd0, 32'd0);
        end
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_full_pending", {26'd0, pending}, 32'd31);
        checkOutput("lit_full_busy", busy, 32'hFFFFFFFE);
        // WAW on x2 is refused
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_waw_ready", {31'd0, issueReady}, 32'd0);

        // Reset mid-sequence overrides a same-cycle issue and writeback
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, k[4:0], 1'b0, 5'd0, 32'd0);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd11, 1'b1, 5'd4, 32'h00000012);
        applyStimulus(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_midrst_busy", busy, 32'd0);
        checkOutput("lit_midrst_pending", {26'd0, pending}, 32'd0);
        checkOutput("lit_midrst_ready", {31'd0, issueReady}, 32'd1);
        checkOutput("lit_midrst_regs4", dutRegs[4], 32'd0);

        // Late writeback after reset writes the file and flags an error
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h0BADF00D);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkOutput("lit_late_err", {31'd0, err}, 32'd1);
        checkOutput("lit_late_regs4", dutRegs[4], 32'h0BADF00D);

        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checkEn = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Integer register file with a pending-write scoreboard for the RISCV32 core. Decode reads two source operands from it and issues instructions only when no operand or destination hazard exists; the writeback stage retires results into it. All 32 architectural registers are exported every cycle as the core's `io_regs_*` debug view.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; addresses are log2(NREGS) = 5 bits.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the rising clock edge of clock; 0 = reset.
- io_rs1_addr  in  5  source operand 1 index.
- io_rs2_addr  in  5  source operand 2 index.
- io_rs1_data  out  XLEN  operand 1 value, with writeback bypass.
- io_rs2_data  out  XLEN  operand 2 value, with writeback bypass.
- io_issue_valid  in  1  decode requests issue of an instruction writing io_issue_rd.
- io_issue_rd  in  5  destination index of the issuing instruction; 0 means no destination.
- io_issue_ready  out  1  no hazard; the issue is accepted when valid && ready.
- io_wb_valid  in  1  writeback of a result this cycle.
- io_wb_rd  in  5  writeback destination index.
- io_wb_data  in  XLEN  writeback value.
- io_busy  out  NREGS  scoreboard bitmask; bit i = 1 means register i has a write outstanding.
- io_pending  out  6  count of outstanding writes, 0..31.
- io_err  out  1  sticky protocol error flag.
- io_regs_0 .. io_regs_31  out  XLEN each  registered contents of x0..x31, with no bypass.

## Operation
- State:
  - regs[1..31], XLEN bits each. regs[0] does not exist; x0 always reads 0.
  - busy[31:1]. busy[0] is constant 0.
  - pending, 6 bits.
  - err, 1 bit.
- Writeback: if wb_valid && wb_rd != 0, then regs[wb_rd] <= wb_data and busy[wb_rd] is cleared. wb_rd == 0 is ignored entirely.
- Read ports (combinational, write-first):
  - rsN_addr == 0 returns 0.
  - Else, if wb_valid && wb_rd == rsN_addr, returns wb_data.
  - Else returns regs[rsN_addr].
- Effective busy: eff_busy[i] = busy[i] && !(wb_valid && wb_rd == i).
- Ready rule: io_issue_ready = !eff_busy[rs1_addr] && !eff_busy[rs2_addr] && !eff_busy[issue_rd].
  - This blocks RAW hazards on both sources and WAW hazards on the destination.
  - io_issue_ready is independent of io_issue_valid.
- Issue: when valid && ready && issue_rd != 0, busy[issue_rd] is set.
  - Same-cycle writeback clearing the same index: the set wins, and the register ends busy.
- pending: next value = pending + (accepted issue with rd != 0) - (wb_valid, wb_rd != 0, busy[wb_rd] == 1).
  - Simultaneous increment and decrement leaves pending unchanged.
  - pending always equals popcount(busy).
- err: set when wb_valid && wb_rd != 0 && busy[wb_rd] == 0, i.e. a writeback with no matching issue.
  - That write still updates regs.
  - err is cleared only by reset.
- Reset (reset == 0 at a clock edge): regs, busy, pending and err all go to 0, overriding any same-cycle issue or writeback.

## Timing
- Read ports: 0-cycle combinational latency, including the bypass.
- io_regs_*, io_busy, io_pending, io_err: registered; they reflect a writeback or issue one cycle after the edge that commits it.
- Issue-to-ready: after issue of rd = k at edge T, any reader of xk sees io_issue_ready = 0 from T until the cycle in which the writeback of k is presented.
  - In that writeback cycle ready returns to 1 and the operand is bypassed.
- Reset values: every output is 0, except io_issue_ready = 1 and io_rs*_data = 0.
- Reset asserted mid-operation drops all outstanding busy bits. A late writeback arriving after reset writes regs and sets err.

## Test plan
- Reset, then write x5 = 0xDEADBEEF (after issuing rd = 5) → next cycle io_regs_5 = 0xDEADBEEF, io_busy = 0, io_pending = 0, io_err = 0.
- Writeback to x0 with 0x12345678 → io_regs_0 = 0, rs1_addr = 0 reads 0, io_err stays 0, pending unchanged.
- Issue rd = 7, then rs1 = 7 on the following cycles → ready = 0. In the writeback cycle with wb_data = 0xA5A5A5A5: ready = 1 and io_rs1_data = 0xA5A5A5A5 that same cycle.
- Issue rd = 3 while simultaneously writing back x3 (busy) → busy[3] = 1 next cycle, pending unchanged, regs[3] updated.
- Writeback to x9 with busy[9] = 0 → io_err = 1 next cycle and stays 1; io_regs_9 updated. Reset → io_err = 0.
- Issue rd = 1..31 on consecutive cycles → io_pending counts to 31 and io_busy = 0xFFFFFFFE. Reset mid-sequence → all cleared on the next edge and ready = 1.
